// File: rtl/data_mem_controller.sv
// data_mem_controller: arbitrates NUM_CONSUMERS LSU read/write request ports
// onto NUM_CHANNELS data-memory channels. Each channel runs its own
// handshake FSM and owns exactly one consumer at a time through a claim bit.
//
// Build option: define RR_ARBITRATION_EN for per-channel round-robin
// arbitration. Without it, each channel grants the lowest-index eligible
// consumer.
//
// Channel FSM
//   state          | meaning
//   ---------------+--------------------------------------------------------
//   IDLE           | free; grants an unclaimed consumer with a request
//   READ_WAITING   | mem_read_valid up, waiting for mem_read_ready
//   WRITE_WAITING  | mem_write_valid up, waiting for mem_write_ready
//   READ_RELAYING  | consumer_read_ready up until consumer drops read valid
//   WRITE_RELAYING | consumer_write_ready up until consumer drops write valid

module data_mem_controller #(
   parameter int NUM_CONSUMERS = 4,
   parameter int NUM_CHANNELS  = 1,
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 16
) (
   input  logic                                    clk,
   input  logic                                    reset,

   input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
   input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
   output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
   input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
   input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,

   output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
   output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
   input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
   input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
   output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
   output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
   output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
   input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

   localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

   typedef enum logic [2:0] {
      IDLE,
      READ_WAITING,
      WRITE_WAITING,
      READ_RELAYING,
      WRITE_RELAYING
   } state_t;

   state_t                           state_q [NUM_CHANNELS];
   state_t                           state_n [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0][CW-1:0]  idx_q, idx_n;
   logic [NUM_CONSUMERS-1:0]         claim_q, claim_n;

   // Claims as seen by the channel currently being evaluated: includes grants
   // made by lower-index channels earlier in the same cycle.
   logic [NUM_CONSUMERS-1:0]         claim_vis;
   logic                             found;
   logic [CW-1:0]                    pick;
   logic [CW-1:0]                    cand;

   logic [NUM_CONSUMERS-1:0]                consumer_read_ready_n;
   logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data_n;
   logic [NUM_CONSUMERS-1:0]                consumer_write_ready_n;
   logic [NUM_CHANNELS-1:0]                 mem_read_valid_n;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address_n;
   logic [NUM_CHANNELS-1:0]                 mem_write_valid_n;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address_n;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data_n;

`ifdef RR_ARBITRATION_EN
   logic [NUM_CHANNELS-1:0][CW-1:0]  ptr_q, ptr_n;
   int                               rr_idx;
`endif

   // Next-state and next-output logic for all channels, evaluated in
   // ascending channel order so lower channels win contested consumers.
   always_comb begin
      state_n                = state_q;
      idx_n                  = idx_q;
      claim_n                = claim_q;
      claim_vis              = claim_q;
      found                  = 1'b0;
      pick                   = '0;
      cand                   = '0;
      consumer_read_ready_n  = consumer_read_ready;
      consumer_read_data_n   = consumer_read_data;
      consumer_write_ready_n = consumer_write_ready;
      mem_read_valid_n       = mem_read_valid;
      mem_read_address_n     = mem_read_address;
      mem_write_valid_n      = mem_write_valid;
      mem_write_address_n    = mem_write_address;
      mem_write_data_n       = mem_write_data;
`ifdef RR_ARBITRATION_EN
      ptr_n                  = ptr_q;
      rr_idx                 = 0;
`endif

      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         found = 1'b0;
         pick  = '0;

         // Search downward so the last hit is the highest-priority candidate.
`ifdef RR_ARBITRATION_EN
         for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
            rr_idx = int'(ptr_q[ch]) + k;
            if (rr_idx >= NUM_CONSUMERS) rr_idx = rr_idx - NUM_CONSUMERS;
            cand = rr_idx[CW-1:0];
            if (!claim_vis[cand] &&
                (consumer_read_valid[cand] || consumer_write_valid[cand])) begin
               found = 1'b1;
               pick  = cand;
            end
         end
`else
         for (int c = NUM_CONSUMERS - 1; c >= 0; c--) begin
            cand = c[CW-1:0];
            if (!claim_vis[cand] &&
                (consumer_read_valid[cand] || consumer_write_valid[cand])) begin
               found = 1'b1;
               pick  = cand;
            end
         end
`endif

         unique case (state_q[ch])
            IDLE: begin
               if (found) begin
                  claim_n[pick]   = 1'b1;
                  claim_vis[pick] = 1'b1;
                  idx_n[ch]       = pick;
`ifdef RR_ARBITRATION_EN
                  if (pick == CW'(NUM_CONSUMERS - 1)) ptr_n[ch] = '0;
                  else                                ptr_n[ch] = pick + 1'b1;
`endif
                  // Reads take precedence when a consumer asks for both.
                  if (consumer_read_valid[pick]) begin
                     mem_read_valid_n[ch]   = 1'b1;
                     mem_read_address_n[ch] = consumer_read_address[pick];
                     state_n[ch]            = READ_WAITING;
                  end else begin
                     mem_write_valid_n[ch]   = 1'b1;
                     mem_write_address_n[ch] = consumer_write_address[pick];
                     mem_write_data_n[ch]    = consumer_write_data[pick];
                     state_n[ch]             = WRITE_WAITING;
                  end
               end
            end
            READ_WAITING: begin
               if (mem_read_ready[ch]) begin
                  mem_read_valid_n[ch]                  = 1'b0;
                  consumer_read_ready_n[idx_q[ch]]      = 1'b1;
                  consumer_read_data_n[idx_q[ch]]       = mem_read_data[ch];
                  state_n[ch]                           = READ_RELAYING;
               end
            end
            WRITE_WAITING: begin
               if (mem_write_ready[ch]) begin
                  mem_write_valid_n[ch]                 = 1'b0;
                  consumer_write_ready_n[idx_q[ch]]     = 1'b1;
                  state_n[ch]                           = WRITE_RELAYING;
               end
            end
            READ_RELAYING: begin
               if (!consumer_read_valid[idx_q[ch]]) begin
                  consumer_read_ready_n[idx_q[ch]]      = 1'b0;
                  claim_n[idx_q[ch]]                    = 1'b0;
                  state_n[ch]                           = IDLE;
               end
            end
            WRITE_RELAYING: begin
               if (!consumer_write_valid[idx_q[ch]]) begin
                  consumer_write_ready_n[idx_q[ch]]     = 1'b0;
                  claim_n[idx_q[ch]]                    = 1'b0;
                  state_n[ch]                           = IDLE;
               end
            end
            default: begin
               state_n[ch] = IDLE;
            end
         endcase
      end
   end

   // State, claim and registered-output update; reset drops everything,
   // including in-flight transactions, without completing them.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int ch = 0; ch < NUM_CHANNELS; ch++) state_q[ch] <= IDLE;
         idx_q                <= '0;
         claim_q              <= '0;
         consumer_read_ready  <= '0;
         consumer_read_data   <= '0;
         consumer_write_ready <= '0;
         mem_read_valid       <= '0;
         mem_read_address     <= '0;
         mem_write_valid      <= '0;
         mem_write_address    <= '0;
         mem_write_data       <= '0;
`ifdef RR_ARBITRATION_EN
         ptr_q                <= '0;
`endif
      end else begin
         state_q              <= state_n;
         idx_q                <= idx_n;
         claim_q              <= claim_n;
         consumer_read_ready  <= consumer_read_ready_n;
         consumer_read_data   <= consumer_read_data_n;
         consumer_write_ready <= consumer_write_ready_n;
         mem_read_valid       <= mem_read_valid_n;
         mem_read_address     <= mem_read_address_n;
         mem_write_valid      <= mem_write_valid_n;
         mem_write_address    <= mem_write_address_n;
         mem_write_data       <= mem_write_data_n;
`ifdef RR_ARBITRATION_EN
         ptr_q                <= ptr_n;
`endif
      end
   end

endmodule

// File: doc/data_mem_controller.md
DATA_MEM_CONTROLLER -- requirements
Module: data_mem_controller

Interface
REQ-001 SHALL have parameter NUM_CONSUMERS, default 4: number of LSU request ports.
REQ-002 SHALL have parameter NUM_CHANNELS, default 1: number of data-memory channels.
REQ-003 SHALL have parameter ADDR_BITS, default 8: data memory address width.
REQ-004 SHALL have parameter DATA_BITS, default 16: data word width.
REQ-005 SHALL have port clk, input, 1 bit: clock; all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port consumer_read_valid, input, [NUM_CONSUMERS]: per-LSU read request.
REQ-008 SHALL have port consumer_read_address, input, [NUM_CONSUMERS][ADDR_BITS]: read address.
REQ-009 SHALL have port consumer_read_ready, output, [NUM_CONSUMERS]: read data valid to LSU.
REQ-010 SHALL have port consumer_read_data, output, [NUM_CONSUMERS][DATA_BITS]: returned read data.
REQ-011 SHALL have port consumer_write_valid, input, [NUM_CONSUMERS]: per-LSU write request.
REQ-012 SHALL have ports consumer_write_address [NUM_CONSUMERS][ADDR_BITS] and consumer_write_data [NUM_CONSUMERS][DATA_BITS], both inputs: write request payload.
REQ-013 SHALL have port consumer_write_ready, output, [NUM_CONSUMERS]: write acknowledged to LSU.
REQ-014 SHALL have ports mem_read_valid (output, [NUM_CHANNELS]), mem_read_address (output, [NUM_CHANNELS][ADDR_BITS]), mem_read_ready (input, [NUM_CHANNELS]) and mem_read_data (input, [NUM_CHANNELS][DATA_BITS]): memory read side.
REQ-015 SHALL have ports mem_write_valid (output, [NUM_CHANNELS]), mem_write_address (output, [NUM_CHANNELS][ADDR_BITS]), mem_write_data (output, [NUM_CHANNELS][DATA_BITS]) and mem_write_ready (input, [NUM_CHANNELS]): memory write side.

Function
REQ-016 Each channel SHALL run an independent FSM with states IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
REQ-017 SHALL keep a claim bit per consumer; a claimed consumer SHALL NOT be selected by any other channel.
REQ-018 IDLE: the channel SHALL select one unclaimed consumer with read or write valid, set its claim, latch its consumer index, and drive the matching mem_*_valid/address(/data) on the next edge; next state READ_WAITING or WRITE_WAITING.
REQ-019 If one consumer has read and write valid simultaneously, the read SHALL be served first.
REQ-020 Channels SHALL be evaluated in ascending index within one cycle, and claims made by lower channels SHALL be visible to higher channels in the same cycle; two channels SHALL NOT take the same consumer.
REQ-021 READ_WAITING: on mem_read_ready=1, the channel SHALL clear mem_read_valid, set consumer_read_ready=1, register consumer_read_data=mem_read_data, and go to READ_RELAYING.
REQ-022 WRITE_WAITING: on mem_write_ready=1, the channel SHALL clear mem_write_valid, set consumer_write_ready=1, and go to WRITE_RELAYING.
REQ-023 *_RELAYING: once the consumer's corresponding valid is 0, the channel SHALL clear the consumer ready, release the claim, and return to IDLE; while valid stays 1, ready SHALL hold at 1.
REQ-024 Latency: mem valid SHALL rise 1 cycle after consumer valid is sampled in IDLE; consumer ready SHALL rise 1 cycle after mem ready is sampled; the channel SHALL be reusable 1 cycle after consumer valid drops.
REQ-025 Address and data SHALL pass through unmodified at full width, with no arithmetic.
REQ-026 consumer_read_data SHALL hold its last value until overwritten by a new read.
REQ-027 A consumer that drops valid while in *_WAITING SHALL NOT abort the transaction; the memory handshake SHALL complete first.

Reset
REQ-028 On reset, all FSMs SHALL go to IDLE, all claim bits SHALL clear, and every output (valid, ready, address, data) SHALL be 0, including in-flight transactions, with no completion.
REQ-029 In the first cycle after reset deasserts, the block SHALL accept requests.

Configuration
REQ-030 With RR_ARBITRATION_EN defined, each channel SHALL keep a rotating start pointer, search from pointer, and set pointer = granted index + 1 (mod NUM_CONSUMERS) on grant; pointer SHALL reset to 0.
REQ-031 Without RR_ARBITRATION_EN, each channel SHALL grant the lowest-index eligible consumer.

Verification
REQ-032 Single read: consumer 2 reads addr 0x10, memory returns 0x1234 after 3 cycles -> mem_read_address[0]=0x10; consumer_read_data[2]=0x1234 with ready high until valid drops.
REQ-033 Single write: consumer 1 writes 0xBEEF to 0x20 -> mem_write_valid/address/data = 1/0x20/0xBEEF until mem_write_ready; then consumer_write_ready[1]=1.
REQ-034 Contention, 1 channel, all 4 consumers read at once -> without the macro, grant order is 0,1,2,3; with RR_ARBITRATION_EN and a second burst, order rotates starting at 0 and then wraps.
REQ-035 NUM_CHANNELS=2, consumers 0 and 3 valid together -> channel 0 takes 0, channel 1 takes 3, no duplicate grant.
REQ-036 Reset asserted during READ_WAITING -> all outputs are 0 next cycle, no consumer_read_ready pulse, and a fresh request then completes normally.
